// File: rtl/filter_pkg.sv
// Shared definitions for the streaming 3x3 filter engine.
package filter_pkg;

  localparam logic [15:0] CMD_PASS   = 16'hA000;
  localparam logic [15:0] CMD_SOBEL  = 16'hA010;
  localparam logic [15:0] CMD_SHARP  = 16'hA020;
  localparam logic [15:0] CMD_MEDIAN = 16'hA030;
  localparam logic [15:0] CMD_ERODE  = 16'hA060;
  localparam logic [15:0] CMD_DILATE = 16'hA070;

  localparam int unsigned BORDER_ZERO = 0;
  localparam int unsigned BORDER_REPL = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Clamp a signed intermediate into [0, hi].
  function automatic int clamp_int(input int value, input int hi);
    if (value < 0) return 0;
    if (value > hi) return hi;
    return value;
  endfunction

  // True for commands the kernel implements.
  function automatic logic cmd_supported(input logic [15:0] op);
    return (op == CMD_PASS) || (op == CMD_SOBEL) || (op == CMD_SHARP) ||
           (op == CMD_MEDIAN) || (op == CMD_ERODE) || (op == CMD_DILATE);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raster line of delay; shifts only when enabled.
module line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] last
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift chain; contents need no reset because border masking hides stale taps.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= data;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign last = mem[DEPTH-1];

endmodule

// File: rtl/filter_stream_engine.sv
// Streaming 3x3 neighbourhood filter with valid/ready in and out.
module filter_stream_engine
  import filter_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned BORDER_MODE  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [15:0]                       command,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0]   s_data,
  input  logic                              s_sof,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [CHANNELS*PIXEL_WIDTH-1:0]   m_data,
  output logic                              m_sof,
  output logic                              m_eof,
  output logic                              busy,
  output logic                              cmd_err,
  output logic                              frame_err
);

  localparam int unsigned W     = IMAGE_WIDTH;
  localparam int unsigned H     = IMAGE_HEIGHT;
  localparam int unsigned PW    = PIXEL_WIDTH;
  localparam int unsigned DW    = CHANNELS * PW;
  localparam int unsigned NPIX  = W * H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned ROW_W = $clog2(H);
  localparam int unsigned COL_W = $clog2(W);
  localparam int          MAX_VAL   = (1 << PW) - 1;
  localparam bit          ZERO_FILL = (BORDER_MODE != BORDER_REPL);

  state_t state, state_next;
  logic out_free, accept, sof_take, run_out, flush_out, produce, shift_en;
  logic [CNT_W-1:0] in_cnt;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [15:0]      cmd;
  logic [DW-1:0]    din, lb0_last, lb1_last, b1, b2, m1, m2, t1, t2;
  logic [CHANNELS-1:0][8:0][PW-1:0] win, taps;
  logic [DW-1:0]    result;

  // Select one tap, substituting zero or the nearest in-frame pixel at borders.
  function automatic logic [PW-1:0] pick(input logic [8:0][PW-1:0] w, input int r, input int c,
                                         input logic top, input logic bot,
                                         input logic lft, input logic rgt);
    int   rr  = r;
    int   cc  = c;
    logic oob = 1'b0;
    if (r == 0 && top) begin rr = 1; oob = 1'b1; end
    if (r == 2 && bot) begin rr = 1; oob = 1'b1; end
    if (c == 0 && lft) begin cc = 1; oob = 1'b1; end
    if (c == 2 && rgt) begin cc = 1; oob = 1'b1; end
    if (oob && ZERO_FILL) return '0;
    return w[4'(rr * 3 + cc)];
  endfunction

  // Per-channel 3x3 operator; taps are row-major with index 4 at the centre.
  function automatic logic [PW-1:0] kernel(input logic [8:0][PW-1:0] p, input logic [15:0] op);
    logic signed [PW+3:0] s [9];
    logic signed [PW+3:0] gx, gy, acc;
    logic [PW-1:0] srt [9];
    logic [PW-1:0] tmp;
    int res;
    res = 0;
    gx  = '0;
    gy  = '0;
    acc = '0;
    tmp = '0;
    for (int i = 0; i < 9; i++) begin
      s[i]   = $signed({4'b0000, p[i]});
      srt[i] = p[i];
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (srt[j] > srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
    case (op)
      CMD_PASS:   res = int'(p[4]);
      CMD_SOBEL: begin
        gx = (s[2] + s[5] + s[5] + s[8]) - (s[0] + s[3] + s[3] + s[6]);
        gy = (s[6] + s[7] + s[7] + s[8]) - (s[0] + s[1] + s[1] + s[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        acc = gx + gy;
        res = clamp_int(int'(acc), MAX_VAL);
      end
      CMD_SHARP: begin
        acc = (s[4] <<< 2) + s[4] - s[1] - s[3] - s[5] - s[7];
        res = clamp_int(int'(acc), MAX_VAL);
      end
      CMD_MEDIAN: res = int'(srt[4]);
      CMD_ERODE:  res = int'(srt[0]);
      CMD_DILATE: res = int'(srt[8]);
      default:    res = 0;
    endcase
    return PW'(res);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state and handshake/shift control.
  always_comb begin
    state_next = state;
    out_free   = !m_valid || m_ready;
    s_ready    = rst && (state != ST_FLUSH) && out_free;
    accept     = s_valid && s_ready;
    sof_take   = accept && s_sof;
    run_out    = accept && !s_sof && (state == ST_RUN);
    flush_out  = (state == ST_FLUSH) && out_free && !(m_valid && m_eof);
    produce    = run_out || flush_out;
    shift_en   = (accept && (s_sof || state != ST_IDLE)) || flush_out;
    case (state)
      ST_IDLE:  if (sof_take) state_next = ST_FILL;
      ST_FILL: begin
        if (sof_take)                               state_next = ST_FILL;
        else if (accept && in_cnt == CNT_W'(W))     state_next = ST_RUN;
      end
      ST_RUN: begin
        if (sof_take)                               state_next = ST_FILL;
        else if (accept && in_cnt == CNT_W'(NPIX - 1)) state_next = ST_FLUSH;
      end
      ST_FLUSH: if (m_valid && m_eof && m_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign din = (state == ST_FLUSH) ? '0 : s_data;

  line_buffer #(.DEPTH(W), .WIDTH(DW)) u_lb0 (.clk(clk), .en(shift_en), .data(din),      .last(lb0_last));
  line_buffer #(.DEPTH(W), .WIDTH(DW)) u_lb1 (.clk(clk), .en(shift_en), .data(lb0_last), .last(lb1_last));

  // Left/centre columns of the 3x3 window, trailing the line-buffer taps.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      b1 <= din;
      b2 <= b1;
      m1 <= lb0_last;
      m2 <= m1;
      t1 <= lb1_last;
      t2 <= t1;
    end
  end

  // Assemble masked windows and run the kernel on every channel.
  always_comb begin
    win    = '0;
    taps   = '0;
    result = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      win[ch][0] = t2[ch*PW +: PW];
      win[ch][1] = t1[ch*PW +: PW];
      win[ch][2] = lb1_last[ch*PW +: PW];
      win[ch][3] = m2[ch*PW +: PW];
      win[ch][4] = m1[ch*PW +: PW];
      win[ch][5] = lb0_last[ch*PW +: PW];
      win[ch][6] = b2[ch*PW +: PW];
      win[ch][7] = b1[ch*PW +: PW];
      win[ch][8] = din[ch*PW +: PW];
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          taps[ch][r*3+c] = pick(win[ch], r, c,
                                 out_row == '0, out_row == ROW_W'(H - 1),
                                 out_col == '0, out_col == COL_W'(W - 1));
        end
      end
      result[ch*PW +: PW] = kernel(taps[ch], cmd);
    end
  end

  // Counters, latched command, status flags and the output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;
      in_cnt    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      cmd       <= '0;
    end else begin
      busy      <= (state_next != ST_IDLE);
      frame_err <= sof_take && (state != ST_IDLE);
      if (sof_take) begin
        cmd     <= command;
        cmd_err <= !cmd_supported(command);
        in_cnt  <= CNT_W'(1);
        out_row <= '0;
        out_col <= '0;
      end else begin
        if (accept && state != ST_IDLE) in_cnt <= in_cnt + CNT_W'(1);
        if (produce) begin
          if (out_col == COL_W'(W - 1)) begin
            out_col <= '0;
            out_row <= out_row + ROW_W'(1);
          end else begin
            out_col <= out_col + COL_W'(1);
          end
        end
      end
      if (produce) begin
        m_valid <= 1'b1;
        m_data  <= result;
        m_sof   <= (out_row == '0) && (out_col == '0);
        m_eof   <= (out_row == ROW_W'(H - 1)) && (out_col == COL_W'(W - 1));
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/filter_stream_engine.md
# filter_stream_engine

Parametrised, streaming successor to the single-pixel filter datapath. It accepts a raster-order pixel stream with a valid/ready handshake and builds a 3x3 neighbourhood internally from two line buffers. It applies the frame-latched filter command to every pixel of every channel and emits a raster-order filtered stream with frame markers. It sits between the decoded-image RAM reader and the image RAM writer, replacing address-driven filtering.

## Interface
- IMAGE_WIDTH, 320, pixels per row (W, >=3)
- IMAGE_HEIGHT, 240, rows per frame (H, >=2)
- PIXEL_WIDTH, 8, bits per channel sample (PW)
- CHANNELS, 1, samples packed per pixel, channel 0 in LSBs
- BORDER_MODE, 0, 0 = out-of-frame taps read 0; 1 = replicate nearest edge pixel
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-low
- command  in  16  filter select, sampled only when a frame-start pixel is accepted
- s_valid / s_ready  in / out  1 / 1  input handshake
- s_data  in  CHANNELS*PW  input pixel
- s_sof  in  1  marks first pixel of a frame
- m_valid / m_ready  out / in  1 / 1  output handshake
- m_data  out  CHANNELS*PW  filtered pixel
- m_sof, m_eof  out  1  first/last output pixel of frame, qualified by m_valid
- busy  out  1  frame in progress (state != IDLE)
- cmd_err  out  1  sticky: frame started with unsupported command; cleared at next accepted s_sof
- frame_err  out  1  one-cycle pulse: s_sof accepted mid-frame

## Operation
- Commands: 16'hA000 passthrough; 16'hA010 Sobel, |Gx|+|Gy| saturated to 2^PW-1; 16'hA020 sharpen, 5*c - N - S - E - W clamped to [0, 2^PW-1]; 16'hA030 median of 9; 16'hA060 erosion (min of 9); 16'hA070 dilation (max of 9). Any other command outputs 0 and sets cmd_err.
- Arithmetic is signed, PW+4 bits internally, then saturated. Each channel is processed independently.
- States:
  - IDLE: s_ready=1; pixels without s_sof are accepted and dropped. An accepted s_sof pixel latches command, resets counters and enters FILL.
  - FILL: accepts the first W+1 pixels, no output; then RUN.
  - RUN: each accepted input k+W+1 produces output k.
  - After the last input pixel (index W*H-1) is accepted, go to FLUSH. In FLUSH, s_ready=0 and the final W+1 outputs are produced using border taps. After m_eof is transferred, go to IDLE.
- Border: the tap mask comes from the output row/col counters. BORDER_MODE selects zero or replicate for rows -1/H and cols -1/W.
- s_sof accepted in FILL/RUN: pulse frame_err, discard pending window, restart the frame with this pixel as pixel 0, latch new command. Outputs already in m_data still complete.

## Timing
- Single output register. s_ready = (state is IDLE/FILL/RUN) && (!m_valid || m_ready).
- Output k is valid in the cycle after input k+W+1 is accepted. During FLUSH, one output is produced per cycle when the output register is free.
- m_data, m_sof and m_eof hold stable while m_valid && !m_ready.
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eof=0, busy=0, cmd_err=0, frame_err=0, state IDLE. s_ready=0 during reset, 1 the first cycle after.
- Reset applies mid-frame with no residue; line buffer contents need not be cleared.
- Throughput: 1 pixel/cycle sustained with m_ready held high.

## Structure
- Package filter_pkg: command localparams (A000–A070), state enum, BORDER_* constants, a sat/clamp function.
- Sub-module line_buffer: depth W, width CHANNELS*PW, enable-gated shift, instantiated twice.
- Per-channel 3x3 kernel is a function or generate loop, not a separate module.

## Test plan
- W=4, H=3, PW=8, command A000, ramp 0..11, m_ready=1 -> output 0..11 in order; m_sof on 0, m_eof on 11; first m_valid the cycle after input 5 is accepted.
- A010, BORDER_MODE=1, flat frame of 100 -> all outputs 0. With left half 0 and right half 255 -> edge columns saturate to 255.
- A030, a single 255 impulse in a zero frame -> all outputs 0. A060/A070 on the same frame -> all 0, and a 3x3 block of 255 respectively.
- Random m_ready (50%) with random s_valid -> output sequence identical to the m_ready=1 run; no drop or duplicate; m_data stable while stalled.
- Command 16'hA040 -> all outputs 0, cmd_err=1; the next frame with A000 clears it.
- s_sof mid-frame at pixel 7 -> frame_err one cycle, followed by a complete 12-pixel frame. rst low at pixel 5 -> all outputs at reset values next cycle, then clean frame.
